// File: rtl/msg_ser_pkg.sv
// Shared types and sizing helpers for the message serializer.
// The MSG_SER_CHECKSUM_EN build option is consumed in msg_serializer.sv.
package msg_ser_pkg;

    typedef enum logic [2:0] {
        T_NOP   = 3'd0,
        T_ONE   = 3'd1,
        T_TWO   = 3'd2,
        T_THREE = 3'd3,
        T_FOUR  = 3'd4
    } msg_tag_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } ser_state_e;

    localparam int DROP_W = 16;

    function automatic int nbeats(input int msg_w, input int beat_w);
        return (msg_w + beat_w - 1) / beat_w;
    endfunction

    // Index counters need at least one bit even for single-beat messages.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/msg_ser_beat_mux.sv
// Selects beat idx_i of a message, MSB-first, with the final beat zero-padded
// in its LSBs. Indices past the last data beat return zero.
module msg_ser_beat_mux
    import msg_ser_pkg::*;
#(
    parameter int MSG_W  = 32,
    parameter int BEAT_W = 8,
    parameter int IDX_W  = 2
) (
    input  logic [MSG_W-1:0]  msg_i,
    input  logic [IDX_W-1:0]  idx_i,
    output logic [BEAT_W-1:0] beat_o
);

    localparam int NBEATS = nbeats(MSG_W, BEAT_W);
    localparam int PAD_W  = NBEATS * BEAT_W - MSG_W;

    logic [NBEATS*BEAT_W-1:0] padded;

    // Left-justify the message so the pad lands in the LSBs of the last beat.
    assign padded = (NBEATS * BEAT_W)'(msg_i) << PAD_W;

    always_comb begin
        beat_o = '0;
        for (int k = 0; k < NBEATS; k++) begin
            if (idx_i == IDX_W'(k)) begin
                beat_o = padded[(NBEATS-1-k)*BEAT_W +: BEAT_W];
            end
        end
    end

endmodule

// File: rtl/msg_serializer.sv
// Accepts tagged messages and streams them out as BEAT_W-wide beats.
// Define MSG_SER_CHECKSUM_EN to append an XOR checksum beat to every message.
//
//   state  | meaning
//   S_IDLE | ready for a message; illegal tags are counted and dropped
//   S_SEND | streaming beats of the registered message
module msg_serializer
    import msg_ser_pkg::*;
#(
    parameter int MSG_W   = 32,
    parameter int BEAT_W  = 8,
    parameter int TAG_W   = 3,
    parameter int MAX_TAG = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MSG_W-1:0]  in_msg,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BEAT_W-1:0] out_data,
    output logic              out_last,
    output logic [TAG_W-1:0]  out_tag,
    output logic [DROP_W-1:0] drop_count,
    output logic              busy
);

    localparam int NBEATS = nbeats(MSG_W, BEAT_W);
`ifdef MSG_SER_CHECKSUM_EN
    localparam int TOTAL_BEATS = NBEATS + 1;
`else
    localparam int TOTAL_BEATS = NBEATS;
`endif
    localparam int               IDX_W     = idx_width(TOTAL_BEATS);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(TOTAL_BEATS - 1);
    localparam logic [31:0]      MAX_TAG_U = MAX_TAG;

    ser_state_e        state_q, state_d;
    logic [MSG_W-1:0]  msg_q, msg_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    logic [TAG_W-1:0]  in_tag;
    logic              tag_legal;
    logic              last_beat;
    logic [BEAT_W-1:0] mux_beat;
    logic [BEAT_W-1:0] beat_data;

    assign in_tag    = in_msg[MSG_W-1 -: TAG_W];
    assign tag_legal = (in_tag != TAG_W'(T_NOP)) && (32'(in_tag) <= MAX_TAG_U);
    assign last_beat = (idx_q == LAST_IDX);

    msg_ser_beat_mux #(
        .MSG_W  (MSG_W),
        .BEAT_W (BEAT_W),
        .IDX_W  (IDX_W)
    ) u_beat_mux (
        .msg_i  (msg_q),
        .idx_i  (idx_q),
        .beat_o (mux_beat)
    );

`ifdef MSG_SER_CHECKSUM_EN
    logic [BEAT_W-1:0] csum_q, csum_d;

    // Running XOR of the data beats; presented in place of the mux on the final beat.
    assign beat_data = last_beat ? csum_q : mux_beat;

    always_comb begin
        csum_d = csum_q;
        if (state_q == S_IDLE) begin
            csum_d = '0;
        end else if (out_ready && !last_beat) begin
            csum_d = csum_q ^ mux_beat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end
`else
    assign beat_data = mux_beat;
`endif

    always_comb begin
        state_d   = state_q;
        msg_d     = msg_q;
        tag_d     = tag_q;
        idx_d     = idx_q;
        drop_d    = drop_q;
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        out_tag   = '0;

        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (tag_legal) begin
                        state_d = S_SEND;
                        msg_d   = in_msg;
                        tag_d   = in_tag;
                        idx_d   = '0;
                    end else if (drop_q != {DROP_W{1'b1}}) begin
                        drop_d = drop_q + DROP_W'(1);
                    end
                end
            end
            S_SEND: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = beat_data;
                out_last  = last_beat;
                out_tag   = tag_q;
                if (out_ready) begin
                    if (last_beat) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            msg_q   <= '0;
            tag_q   <= '0;
            idx_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            msg_q   <= msg_d;
            tag_q   <= tag_d;
            idx_q   <= idx_d;
            drop_q  <= drop_d;
        end
    end

    assign drop_count = drop_q;

endmodule

// File: tb/tb_msg_serializer.sv
// Self-checking bench for msg_serializer: directed literal cases, then random
// traffic compared every cycle against a queue-based model of the beat stream.
module tb_msg_serializer;

`ifdef MSG_SER_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif
    localparam int NB32 = CSUM ? 5 : 4;
    localparam int NB20 = CSUM ? 4 : 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_msg;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic [2:0]  out_tag;
    logic [15:0] drop_count;
    logic        busy;

    logic        v20;
    logic        rdy20;
    logic [19:0] m20;
    logic        o20_valid;
    logic [7:0]  o20_data;
    logic        o20_last;
    logic [2:0]  o20_tag;
    logic [15:0] o20_drop;
    logic        o20_busy;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [7:0] exp_d[$];
    bit         exp_l[$];
    int         exp_tag = 0;
    int         exp_drop = 0;

    msg_serializer dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_msg     (in_msg),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_tag    (out_tag),
        .drop_count (drop_count),
        .busy       (busy)
    );

    msg_serializer #(.MSG_W(20), .BEAT_W(8), .TAG_W(3), .MAX_TAG(4)) dut20 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (v20),
        .in_ready   (),
        .in_msg     (m20),
        .out_valid  (o20_valid),
        .out_ready  (rdy20),
        .out_data   (o20_data),
        .out_last   (o20_last),
        .out_tag    (o20_tag),
        .drop_count (o20_drop),
        .busy       (o20_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] m);
        step();
        in_valid = 1'b1;
        in_msg   = m;
        step();
        in_valid = 1'b0;
    endtask

    // Reference: an accepted legal message becomes a list of beats; the head of
    // the list is what must be on the output, and it leaves on a handshake.
    always @(posedge clk) begin
        if (rst) begin
            exp_d.delete();
            exp_l.delete();
            exp_drop = 0;
            exp_tag  = 0;
        end else if (exp_d.size() == 0) begin
            if (in_valid) begin
                int t;
                logic [7:0] x;
                t = int'(in_msg[31:29]);
                if (t == 0 || t > 4) begin
                    if (exp_drop < 65535) exp_drop++;
                end else begin
                    exp_tag = t;
                    x = 8'h00;
                    for (int k = 0; k < 4; k++) begin
                        logic [7:0] b;
                        b = 8'((in_msg >> (24 - 8 * k)) & 32'hFF);
                        x = x ^ b;
                        exp_d.push_back(b);
                        exp_l.push_back(k == 3 && !CSUM);
                    end
                    if (CSUM) begin
                        exp_d.push_back(x);
                        exp_l.push_back(1'b1);
                    end
                end
            end
        end else if (out_ready) begin
            void'(exp_d.pop_front());
            void'(exp_l.pop_front());
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            bit ne;
            ne = (exp_d.size() != 0);
            chk("m_out_valid", out_valid, ne);
            chk("m_busy", busy, ne);
            chk("m_in_ready", in_ready, !ne);
            chk("m_out_data", out_data, ne ? exp_d[0] : 8'h00);
            chk("m_out_last", out_last, ne ? exp_l[0] : 1'b0);
            chk("m_out_tag", out_tag, ne ? exp_tag : 0);
            chk("m_drop_count", drop_count, exp_drop);
        end
    end

    initial begin
        logic [7:0] exp22[5];
        logic [7:0] exp20[4];
        exp22[0] = 8'h81; exp22[1] = 8'h23; exp22[2] = 8'h45; exp22[3] = 8'h67; exp22[4] = 8'h80;
        exp20[0] = 8'h3B; exp20[1] = 8'hCD; exp20[2] = 8'hE0; exp20[3] = 8'h16;

        rst = 1'b1; in_valid = 1'b0; in_msg = '0; out_ready = 1'b1;
        v20 = 1'b0; m20 = '0; rdy20 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_drop", drop_count, 0);

        // Tag-4 message, sink always ready.
        send(32'h8123_4567);
        for (int k = 0; k < NB32; k++) begin
            chk("d22_valid", out_valid, 1);
            chk("d22_data", out_data, exp22[k]);
            chk("d22_last", out_last, k == NB32 - 1);
            chk("d22_tag", out_tag, 4);
            step();
        end
        chk("d22_idle_valid", out_valid, 0);
        chk("d22_idle_ready", in_ready, 1);

        // NOP and out-of-range tags are dropped.
        send(32'h0000_00FF);
        chk("d23_valid0", out_valid, 0);
        chk("d23_drop1", drop_count, 1);
        chk("d23_ready0", in_ready, 1);
        send(32'hA000_0000);
        chk("d23_valid1", out_valid, 0);
        chk("d23_drop2", drop_count, 2);
        chk("d23_ready1", in_ready, 1);

        // Backpressure on the second beat.
        send(32'h8123_4567);
        chk("d24_b0", out_data, 8'h81);
        step();
        out_ready = 1'b0;
        chk("d24_hold0", out_data, 8'h23);
        repeat (2) begin
            step();
            chk("d24_hold_data", out_data, 8'h23);
            chk("d24_hold_valid", out_valid, 1);
            chk("d24_hold_last", out_last, 0);
            chk("d24_hold_tag", out_tag, 4);
        end
        out_ready = 1'b1;
        step();
        chk("d24_b2", out_data, 8'h45);
        step();
        chk("d24_b3", out_data, 8'h67);
        repeat (NB32 - 3) step();
        chk("d24_idle", out_valid, 0);

        // Reset in the middle of a message.
        send(32'h8123_4567);
        step();
        step();
        chk("d26_b2", out_data, 8'h45);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("d26_valid", out_valid, 0);
        chk("d26_ready", in_ready, 1);
        chk("d26_drop", drop_count, 0);
        repeat (4) begin
            step();
            chk("d26_no_beats", out_valid, 0);
        end

        // Random traffic.
        for (int c = 0; c < 4000; c++) begin
            step();
            rst       = ($urandom_range(0, 299) == 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            in_msg    = $urandom;
            in_msg[31:29] = 3'($urandom_range(0, 7));
            out_ready = ($urandom_range(0, 3) != 0);
        end
        step();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (10) step();

        // Non-multiple width: 20-bit message in 8-bit beats.
        v20 = 1'b1;
        m20 = 20'h3BCDE;
        step();
        v20 = 1'b0;
        for (int k = 0; k < NB20; k++) begin
            chk("d25_valid", o20_valid, 1);
            chk("d25_data", o20_data, exp20[k]);
            chk("d25_last", o20_last, k == NB20 - 1);
            chk("d25_tag", o20_tag, 1);
            chk("d25_busy", o20_busy, 1);
            step();
        end
        chk("d25_idle", o20_valid, 0);
        chk("d25_drop", o20_drop, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
